// File: rtl/digit_bbox_detect.sv
// Bounding box of the foreground pixels in a binarized, raster-ordered frame.
// The box is reported once per completed frame with a one-cycle bbox_valid
// pulse (used downstream as knn_en). bbox_empty qualifies the pulse when the
// frame held no usable box; the box outputs then keep their previous value.
//
// Optional feature: define BBOX_MIN_SIZE_EN to treat boxes narrower or shorter
// than MIN_SIZE pixels as empty. Without the macro MIN_SIZE has no effect.
module digit_bbox_detect #(
  parameter int unsigned IMG_W    = 640,
  parameter int unsigned IMG_H    = 480,
  parameter int unsigned MIN_SIZE = 4
) (
  input  logic       clk_en,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic       pix_valid,
  input  logic       pix_bin,
  output logic [9:0] postion_lu_x,
  output logic [9:0] postion_lu_y,
  output logic [9:0] postion_rd_x,
  output logic [9:0] postion_rd_y,
  output logic       bbox_valid,
  output logic       bbox_empty
);

  localparam int unsigned CW = 10;
  localparam logic [CW-1:0] XLast = CW'(IMG_W - 1);
  localparam logic [CW-1:0] YLast = CW'(IMG_H - 1);

  // Reject geometries the 10-bit coordinate ports cannot describe, and a
  // minimum size that no box could ever reach.
  if (IMG_W < 2 || IMG_W > 1024 || IMG_H < 2 || IMG_H > 1024 || MIN_SIZE > 1024)
  begin : g_bad_cfg
    $error("digit_bbox_detect: parameter out of range");
  end

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          has_q, has_d;
  logic [CW-1:0] min_x_q, min_x_d, max_x_q, max_x_d;
  logic [CW-1:0] min_y_q, min_y_d, max_y_q, max_y_d;
  logic [CW-1:0] lu_x_q, lu_y_q, rd_x_q, rd_y_q;
  logic          empty_q;

  logic          accept;
  logic          last_pix;
  logic          fg;
  logic          has_base;
  logic [CW-1:0] cur_x, cur_y;
  logic          box_small;
  logic          report_empty;
  logic          show_box;

  // Pixel acceptance; a frame_start cycle restarts the raster at (0,0).
  always_comb begin
    cur_x    = frame_start ? '0 : x_q;
    cur_y    = frame_start ? '0 : y_q;
    accept   = pix_valid & (frame_start | (state_q == StScan));
    last_pix = accept & (cur_x == XLast) & (cur_y == YLast);
    fg       = accept & pix_bin;
    // Running box is dropped on a restart and once it has been reported.
    has_base = has_q & ~frame_start & (state_q != StDone);
  end

  // Frame sequencing: IDLE -> SCAN -> DONE -> IDLE, frame_start always restarts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (frame_start) state_d = StScan;
      StScan:  if (last_pix) state_d = StDone;
      StDone:  state_d = frame_start ? StScan : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Raster position of the next accepted pixel.
  always_comb begin
    x_d = frame_start ? '0 : x_q;
    y_d = frame_start ? '0 : y_q;
    if (accept) begin
      if (cur_x == XLast) begin
        x_d = '0;
        y_d = (cur_y == YLast) ? '0 : cur_y + CW'(1);
      end else begin
        x_d = cur_x + CW'(1);
        y_d = cur_y;
      end
    end
  end

  // Running min/max of foreground coordinates.
  always_comb begin
    has_d   = has_base | fg;
    min_x_d = has_base ? min_x_q : '0;
    max_x_d = has_base ? max_x_q : '0;
    min_y_d = has_base ? min_y_q : '0;
    max_y_d = has_base ? max_y_q : '0;
    if (fg) begin
      if (!has_base) begin
        min_x_d = cur_x;
        max_x_d = cur_x;
        min_y_d = cur_y;
        max_y_d = cur_y;
      end else begin
        if (cur_x < min_x_q) min_x_d = cur_x;
        if (cur_x > max_x_q) max_x_d = cur_x;
        if (cur_y < min_y_q) min_y_d = cur_y;
        if (cur_y > max_y_q) max_y_d = cur_y;
      end
    end
  end

`ifdef BBOX_MIN_SIZE_EN
  logic [CW:0] box_w, box_h;

  // Box extent; one extra bit so a full-width box does not wrap.
  always_comb begin
    box_w     = {1'b0, max_x_q} - {1'b0, min_x_q} + (CW + 1)'(1);
    box_h     = {1'b0, max_y_q} - {1'b0, min_y_q} + (CW + 1)'(1);
    box_small = (32'(box_w) < MIN_SIZE) | (32'(box_h) < MIN_SIZE);
  end
`else
  // Size filter disabled: any foreground box is reported.
  always_comb begin
    box_small = 1'b0;
  end
`endif

  // Report during DONE unless a new frame pre-empts it; otherwise hold.
  always_comb begin
    bbox_valid   = (state_q == StDone) & ~frame_start;
    report_empty = ~has_q | box_small;
    show_box     = bbox_valid & ~report_empty;
    postion_lu_x = show_box ? min_x_q : lu_x_q;
    postion_lu_y = show_box ? min_y_q : lu_y_q;
    postion_rd_x = show_box ? max_x_q : rd_x_q;
    postion_rd_y = show_box ? max_y_q : rd_y_q;
    bbox_empty   = bbox_valid ? report_empty : empty_q;
  end

  // State, counters, running box and held report registers.
  always_ff @(posedge clk_en or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      has_q   <= 1'b0;
      min_x_q <= '0;
      max_x_q <= '0;
      min_y_q <= '0;
      max_y_q <= '0;
      lu_x_q  <= '0;
      lu_y_q  <= '0;
      rd_x_q  <= '0;
      rd_y_q  <= '0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      has_q   <= has_d;
      min_x_q <= min_x_d;
      max_x_q <= max_x_d;
      min_y_q <= min_y_d;
      max_y_q <= max_y_d;
      lu_x_q  <= postion_lu_x;
      lu_y_q  <= postion_lu_y;
      rd_x_q  <= postion_rd_x;
      rd_y_q  <= postion_rd_y;
      empty_q <= bbox_empty;
    end
  end

endmodule

// File: tb/tb_digit_bbox_detect.sv
// Randomized bench for digit_bbox_detect on an 8x8 frame.
module tb_digit_bbox_detect;

  localparam int W        = 8;
  localparam int H        = 8;
  localparam int N        = W * H;
  localparam int MIN_SIZE = 4;

  typedef logic img_t [N];
  typedef struct {
    longint     cyc;
    logic [9:0] lx, ly, rx, ry;
    logic       e;
  } pulse_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       pix_valid = 1'b0;
  logic       pix_bin = 1'b0;
  logic [9:0] lu_x, lu_y, rd_x, rd_y;
  logic       bbox_valid, bbox_empty;

  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  pulse_t pq[$];

  logic [9:0] exp_lx = '0, exp_ly = '0, exp_rx = '0, exp_ry = '0;
  logic       exp_e = 1'b0;

  digit_bbox_detect #(
    .IMG_W   (W),
    .IMG_H   (H),
    .MIN_SIZE(MIN_SIZE)
  ) dut (
    .clk_en      (clk),
    .reset_n     (rst_n),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .pix_bin     (pix_bin),
    .postion_lu_x(lu_x),
    .postion_lu_y(lu_y),
    .postion_rd_x(rd_x),
    .postion_rd_y(rd_y),
    .bbox_valid  (bbox_valid),
    .bbox_empty  (bbox_empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every report pulse mid-cycle.
  always @(negedge clk) begin
    if (bbox_valid === 1'b1) pq.push_back('{cyc, lu_x, lu_y, rd_x, rd_y, bbox_empty});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: bounding box straight from the image contents.
  function automatic void update_expect(input img_t img);
    bit any = 0;
    int lx = 0, ly = 0, rx = 0, ry = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (img[y * W + x]) begin
          if (!any) begin
            lx = x; rx = x; ly = y; ry = y; any = 1;
          end else begin
            if (x < lx) lx = x;
            if (x > rx) rx = x;
            if (y < ly) ly = y;
            if (y > ry) ry = y;
          end
        end
      end
    end
`ifdef BBOX_MIN_SIZE_EN
    if (any && ((rx - lx + 1) < MIN_SIZE || (ry - ly + 1) < MIN_SIZE)) any = 0;
`endif
    exp_e = !any;
    if (any) begin
      exp_lx = 10'(lx); exp_ly = 10'(ly); exp_rx = 10'(rx); exp_ry = 10'(ry);
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      frame_start = 1'b0; pix_valid = 1'b0; pix_bin = 1'b0;
    end
  endtask

  // Start a frame and deliver npix pixels with random pix_valid gaps.
  task automatic drive_pixels(input img_t img, input int npix, input int gap,
                              output longint last);
    int idx = 0;
    bit first = 1;
    bit pv;
    last = 0;
    while (idx < npix) begin
      @(posedge clk); #1;
      frame_start = first;
      first = 0;
      pv = ($urandom_range(99) >= gap);
      pix_valid = pv;
      pix_bin = pv ? img[idx] : 1'($urandom_range(1));
      if (pv) begin
        last = cyc;
        idx++;
      end
    end
  endtask

  task automatic run_frame(input img_t img, input int gap, output int n, output pulse_t p,
                           output longint last);
    drive_pixels(img, N, gap, last);
    idle(3);
    n = pq.size();
    p = (n > 0) ? pq[0] : '{0, 10'd0, 10'd0, 10'd0, 10'd0, 1'b0};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bbox_valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b want 0", bbox_valid); end
    checks++; if (bbox_empty !== 1'b0) begin errors++; $display("FAIL reset empty: got %b want 0", bbox_empty); end
    checks++; if (lu_x !== 10'd0) begin errors++; $display("FAIL reset lu_x: got %0d want 0", lu_x); end
    checks++; if (lu_y !== 10'd0) begin errors++; $display("FAIL reset lu_y: got %0d want 0", lu_y); end
    checks++; if (rd_x !== 10'd0) begin errors++; $display("FAIL reset rd_x: got %0d want 0", rd_x); end
    checks++; if (rd_y !== 10'd0) begin errors++; $display("FAIL reset rd_y: got %0d want 0", rd_y); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_two_corners();
    img_t img = '{default: 1'b0};
    int n; pulse_t p; longint last;
    img[0] = 1'b1;
    img[4 * W + 4] = 1'b1;
    pq.delete();
    run_frame(img, 0, n, p, last);
    update_expect(img);
    checks++; if (n != 1) begin errors++; $display("FAIL corners count: got %0d want 1", n); end
    checks++; if (p.cyc != last + 1) begin errors++; $display("FAIL corners latency: got cyc %0d want %0d", p.cyc, last + 1); end
    checks++; if ({p.lx, p.ly, p.rx, p.ry, p.e} !== {10'd0, 10'd0, 10'd4, 10'd4, 1'b0}) begin
      errors++; $display("FAIL corners box: got (%0d,%0d,%0d,%0d,e%b) want (0,0,4,4,e0)", p.lx, p.ly, p.rx, p.ry, p.e);
    end
    checks++; if ({lu_x, lu_y, rd_x, rd_y, bbox_empty} !== {exp_lx, exp_ly, exp_rx, exp_ry, exp_e}) begin
      errors++; $display("FAIL corners hold: got (%0d,%0d,%0d,%0d,e%b)", lu_x, lu_y, rd_x, rd_y, bbox_empty);
    end
  endtask

  task automatic test_empty();
    img_t img = '{default: 1'b0};
    int n; pulse_t p; longint last;
    pq.delete();
    run_frame(img, 20, n, p, last);
    update_expect(img);
    checks++; if (n != 1) begin errors++; $display("FAIL empty count: got %0d want 1", n); end
    checks++; if (p.cyc != last + 1) begin errors++; $display("FAIL empty latency: got cyc %0d want %0d", p.cyc, last + 1); end
    checks++; if ({p.lx, p.ly, p.rx, p.ry, p.e} !== {exp_lx, exp_ly, exp_rx, exp_ry, 1'b1}) begin
      errors++; $display("FAIL empty box: got (%0d,%0d,%0d,%0d,e%b) want (%0d,%0d,%0d,%0d,e1)",
                        p.lx, p.ly, p.rx, p.ry, p.e, exp_lx, exp_ly, exp_rx, exp_ry);
    end
    checks++; if (bbox_empty !== 1'b1) begin errors++; $display("FAIL empty hold: got %b want 1", bbox_empty); end
  endtask

  task automatic test_single_corner();
    img_t img = '{default: 1'b0};
    int n; pulse_t p; longint last;
    img[N - 1] = 1'b1;
    pq.delete();
    run_frame(img, 35, n, p, last);
    update_expect(img);
    checks++; if (n != 1) begin errors++; $display("FAIL single count: got %0d want 1", n); end
    checks++; if (p.cyc != last + 1) begin errors++; $display("FAIL single latency: got cyc %0d want %0d", p.cyc, last + 1); end
    checks++; if ({p.lx, p.ly, p.rx, p.ry, p.e} !== {exp_lx, exp_ly, exp_rx, exp_ry, exp_e}) begin
      errors++; $display("FAIL single box: got (%0d,%0d,%0d,%0d,e%b) want (%0d,%0d,%0d,%0d,e%b)",
                        p.lx, p.ly, p.rx, p.ry, p.e, exp_lx, exp_ly, exp_rx, exp_ry, exp_e);
    end
  endtask

  task automatic test_abort();
    img_t a = '{default: 1'b0};
    img_t b = '{default: 1'b0};
    int n; pulse_t p; longint last, last_a;
    a[1 * W + 0] = 1'b1;
    a[2 * W + 7] = 1'b1;
    b[5 * W + 5] = 1'b1;
    b[6 * W + 6] = 1'b1;
    b[3 * W + 2] = 1'b1;
    b[6 * W + 2] = 1'b1;
    pq.delete();
    drive_pixels(a, 30, 10, last_a);
    run_frame(b, 10, n, p, last);
    update_expect(b);
    checks++; if (n != 1) begin errors++; $display("FAIL abort count: got %0d want 1", n); end
    checks++; if (p.cyc != last + 1) begin errors++; $display("FAIL abort latency: got cyc %0d want %0d", p.cyc, last + 1); end
    checks++; if ({p.lx, p.ly, p.rx, p.ry, p.e} !== {exp_lx, exp_ly, exp_rx, exp_ry, exp_e}) begin
      errors++; $display("FAIL abort box: got (%0d,%0d,%0d,%0d,e%b) want (%0d,%0d,%0d,%0d,e%b)",
                        p.lx, p.ly, p.rx, p.ry, p.e, exp_lx, exp_ly, exp_rx, exp_ry, exp_e);
    end
  endtask

  task automatic test_start_in_done();
    img_t a = '{default: 1'b0};
    img_t b = '{default: 1'b0};
    int n; pulse_t p; longint last, last_a;
    a[0 * W + 1] = 1'b1;
    a[7 * W + 6] = 1'b1;
    b[2 * W + 3] = 1'b1;
    b[5 * W + 7] = 1'b1;
    pq.delete();
    drive_pixels(a, N, 0, last_a);
    // Next frame_start lands exactly in the DONE cycle of frame a.
    run_frame(b, 0, n, p, last);
    update_expect(b);
    checks++; if (n != 1) begin errors++; $display("FAIL done_restart count: got %0d want 1", n); end
    checks++; if (p.cyc != last + 1) begin errors++; $display("FAIL done_restart latency: got cyc %0d want %0d", p.cyc, last + 1); end
    checks++; if ({p.lx, p.ly, p.rx, p.ry, p.e} !== {exp_lx, exp_ly, exp_rx, exp_ry, exp_e}) begin
      errors++; $display("FAIL done_restart box: got (%0d,%0d,%0d,%0d,e%b) want (%0d,%0d,%0d,%0d,e%b)",
                        p.lx, p.ly, p.rx, p.ry, p.e, exp_lx, exp_ly, exp_rx, exp_ry, exp_e);
    end
  endtask

  task automatic test_reset_mid_frame();
    img_t a = '{default: 1'b1};
    img_t b = '{default: 1'b0};
    int n; pulse_t p; longint last;
    b[3 * W + 1] = 1'b1;
    b[4 * W + 6] = 1'b1;
    pq.delete();
    drive_pixels(a, 20, 0, last);
    @(posedge clk); #1;
    rst_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
    #1;
    exp_lx = '0; exp_ly = '0; exp_rx = '0; exp_ry = '0; exp_e = 1'b0;
    checks++; if ({lu_x, lu_y, rd_x, rd_y, bbox_empty, bbox_valid} !== {40'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL midreset outputs: got (%0d,%0d,%0d,%0d,e%b,v%b) want zeros",
                        lu_x, lu_y, rd_x, rd_y, bbox_empty, bbox_valid);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // Pixels without a frame_start must be ignored.
    repeat (70) begin
      @(posedge clk); #1;
      pix_valid = 1'b1; pix_bin = 1'($urandom_range(1));
    end
    idle(3);
    checks++; if (pq.size() != 0) begin errors++; $display("FAIL midreset spurious: got %0d pulses want 0", pq.size()); end
    checks++; if ({lu_x, lu_y, rd_x, rd_y, bbox_empty} !== {40'd0, 1'b0}) begin
      errors++; $display("FAIL midreset hold: got (%0d,%0d,%0d,%0d,e%b) want zeros", lu_x, lu_y, rd_x, rd_y, bbox_empty);
    end
    pq.delete();
    run_frame(b, 15, n, p, last);
    update_expect(b);
    checks++; if (n != 1) begin errors++; $display("FAIL midreset count: got %0d want 1", n); end
    checks++; if ({p.lx, p.ly, p.rx, p.ry, p.e} !== {exp_lx, exp_ly, exp_rx, exp_ry, exp_e}) begin
      errors++; $display("FAIL midreset box: got (%0d,%0d,%0d,%0d,e%b) want (%0d,%0d,%0d,%0d,e%b)",
                        p.lx, p.ly, p.rx, p.ry, p.e, exp_lx, exp_ly, exp_rx, exp_ry, exp_e);
    end
  endtask

  task automatic test_start_pixel();
    img_t img = '{default: 1'b0};
    int n; pulse_t p; longint last;
    img[0] = 1'b1;
    pq.delete();
    run_frame(img, 0, n, p, last);
    update_expect(img);
    checks++; if (n != 1) begin errors++; $display("FAIL start_pixel count: got %0d want 1", n); end
    checks++; if ({p.lx, p.ly, p.rx, p.ry, p.e} !== {exp_lx, exp_ly, exp_rx, exp_ry, exp_e}) begin
      errors++; $display("FAIL start_pixel box: got (%0d,%0d,%0d,%0d,e%b) want (%0d,%0d,%0d,%0d,e%b)",
                        p.lx, p.ly, p.rx, p.ry, p.e, exp_lx, exp_ly, exp_rx, exp_ry, exp_e);
    end
  endtask

  task automatic test_random_frames();
    int dens_tab [4] = '{0, 3, 10, 40};
    for (int f = 0; f < 8; f++) begin
      img_t img;
      int n; pulse_t p; longint last;
      int dens = dens_tab[$urandom_range(3)];
      for (int i = 0; i < N; i++) img[i] = ($urandom_range(99) < dens);
      pq.delete();
      run_frame(img, $urandom_range(40), n, p, last);
      update_expect(img);
      checks++; if (n != 1) begin errors++; $display("FAIL random%0d count: got %0d want 1", f, n); end
      checks++; if (p.cyc != last + 1) begin errors++; $display("FAIL random%0d latency: got cyc %0d want %0d", f, p.cyc, last + 1); end
      checks++; if ({p.lx, p.ly, p.rx, p.ry, p.e} !== {exp_lx, exp_ly, exp_rx, exp_ry, exp_e}) begin
        errors++; $display("FAIL random%0d box: got (%0d,%0d,%0d,%0d,e%b) want (%0d,%0d,%0d,%0d,e%b)",
                          f, p.lx, p.ly, p.rx, p.ry, p.e, exp_lx, exp_ly, exp_rx, exp_ry, exp_e);
      end
      checks++; if ({lu_x, lu_y, rd_x, rd_y, bbox_empty} !== {exp_lx, exp_ly, exp_rx, exp_ry, exp_e}) begin
        errors++; $display("FAIL random%0d hold: got (%0d,%0d,%0d,%0d,e%b)", f, lu_x, lu_y, rd_x, rd_y, bbox_empty);
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_corners();
    test_empty();
    test_single_corner();
    test_abort();
    test_start_in_done();
    test_reset_mid_frame();
    test_start_pixel();
    test_random_frames();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
